game_sequencer: RTL
===================

Name: game_sequencer

Overview:
Frame-level game controller that drives the paddle block's endgame and animate inputs through IDLE, SERVE, PLAY, MISS, OVER and WIN phases, and keeps the life count. It also shares the paddle between two command sources, the player buttons and a demo autopilot that tracks the ball. It sits between the button inputs, the ball/brick logic and the paddle block, and runs on the same base clock and animation strobe.

Parameters:
LIVES, 3, lives loaded at game start (1..3)
IDLE_FRAMES, 600, idle strobes without a button press before demo mode starts
SERVE_FRAMES, 60, strobes the serve freeze lasts
MISS_FRAMES, 90, strobes the post-miss freeze lasts
HOLD_FRAMES, 120, strobes OVER/WIN ignore buttons
DEADBAND, 8, autopilot tolerance in pixels inside paddle edges

Ports:
i_clk  in  1  base clock
i_rst_n  in  1  asynchronous active-low reset
i_ani_stb  in  1  animation strobe, one clock pulse per frame
i_btn_lr  in  2  player buttons: bit 0 right, bit 1 left
i_ball_x  in  12  ball centre x
i_pad_x1  in  12  paddle left edge
i_pad_x2  in  12  paddle right edge
i_ball_miss  in  1  one-clock pulse: ball passed the paddle
i_bricks_clear  in  1  one-clock pulse: last brick removed
o_endgame  out  1  paddle/ball reset request
o_animate  out  1  animate enable
o_paddle_lr  out  2  arbitrated paddle command, same encoding as i_btn_lr
o_lives  out  2  remaining lives
o_state  out  3  IDLE=0 SERVE=1 PLAY=2 MISS=3 OVER=4 WIN=5
o_demo  out  1  autopilot owns the paddle

Behaviour:
- Reset (asynchronous, i_rst_n=0) sets: state IDLE, o_endgame=1, o_animate=0, o_paddle_lr=0, o_lives=LIVES, o_demo=0, frame counter 0, event latches 0.
- All outputs are registered.
- Event latching: i_ball_miss and i_bricks_clear set sticky latches on any clock. Latches are consumed and cleared on the next i_ani_stb. A pulse coinciding with the strobe is consumed on that strobe.
- Timing: state transitions and frame-counter updates happen only on clocks with i_ani_stb=1. The counter clears on every state change.
- Button press: press = |i_btn_lr, sampled at the strobe.
- Outputs by state:
  - IDLE: endgame=1, animate=0.
  - SERVE: endgame=0, animate=0.
  - PLAY: endgame=0, animate=1.
  - MISS: endgame=0, animate=0.
  - OVER/WIN: endgame=1, animate=0.
- IDLE:
  - press -> SERVE, lives=LIVES, demo=0.
  - counter reaches IDLE_FRAMES-1 -> SERVE, lives=LIVES, demo=1.
- SERVE: after SERVE_FRAMES strobes -> PLAY.
- PLAY:
  - miss latch -> MISS, lives decremented by 1. Miss has priority over clear on the same strobe.
  - clear latch (no miss) -> WIN.
- MISS: after MISS_FRAMES strobes, lives==0 -> OVER, else -> SERVE.
- OVER/WIN:
  - For the first HOLD_FRAMES strobes, buttons are ignored.
  - After that, press -> SERVE with lives=LIVES and demo=0.
  - If demo=1, go to IDLE automatically after HOLD_FRAMES, demo cleared.
- Demo abort: press at any strobe while demo=1 in SERVE/PLAY/MISS -> IDLE, demo=0, lives=LIVES. Abort beats all other transitions.
- Lives never wrap: decrement only from nonzero.
- Paddle arbitration, evaluated every clock, 1-cycle latency:
  - demo=0: o_paddle_lr = i_btn_lr.
  - demo=1, 13-bit unsigned compares:
    - i_ball_x < i_pad_x1+DEADBAND -> 2'b10.
    - Otherwise, i_ball_x > i_pad_x2-DEADBAND (saturating at 0) -> 2'b01.
    - Otherwise 2'b00.
  - o_paddle_lr is forced to 0 whenever o_animate=0.

Optional Feature:
- Macro GAME_SEQ_DEMO_EN.
- Defined: autopilot and IDLE timeout present as above.
- Undefined:
  - No IDLE timeout; IDLE leaves only on a press.
  - o_demo tied 0.
  - o_paddle_lr = registered i_btn_lr gated by o_animate.
  - i_ball_x, i_pad_x1 and i_pad_x2 are unused.

Test Plan:
- Reset, then i_btn_lr=2'b01 at the first strobe -> o_state=1, o_endgame=0, o_lives=3. After 60 strobes: o_state=2, o_animate=1, o_paddle_lr=2'b01 one clock after the button.
- In PLAY, three i_ball_miss pulses, each followed by a 90-strobe wait -> o_lives 2, 1, 0, then o_state=4 and o_endgame=1. Buttons ignored for 120 strobes, then a press -> o_state=1, o_lives=3.
- i_ball_miss and i_bricks_clear in the same frame during PLAY -> o_state=3, o_lives decremented, no WIN.
- Bench with IDLE_FRAMES=4 and no buttons -> after the 4th strobe o_demo=1. In PLAY with i_pad_x1=100, i_pad_x2=160: i_ball_x=50 -> o_paddle_lr=2'b10; 130 -> 2'b00; 200 -> 2'b01. i_btn_lr=2'b10 -> IDLE, o_demo=0.
- Assert i_rst_n low mid-PLAY between clock edges -> outputs immediately at reset values: o_animate=0, o_endgame=1, o_state=0.
- GAME_SEQ_DEMO_EN undefined, no buttons for 1000 strobes -> o_state stays 0, o_demo=0.

Source files
------------

// File: rtl/game_sequencer_if.sv
// Bundle of the game sequencer's frame-level inputs and paddle/status outputs.
// The slave modport is the sequencer; the master modport is the surrounding game logic.
interface game_sequencer_if;
  logic        i_ani_stb;
  logic [1:0]  i_btn_lr;
  logic [11:0] i_ball_x;
  logic [11:0] i_pad_x1;
  logic [11:0] i_pad_x2;
  logic        i_ball_miss;
  logic        i_bricks_clear;
  logic        o_endgame;
  logic        o_animate;
  logic [1:0]  o_paddle_lr;
  logic [1:0]  o_lives;
  logic [2:0]  o_state;
  logic        o_demo;

  modport slave (
    input  i_ani_stb, i_btn_lr, i_ball_x, i_pad_x1, i_pad_x2, i_ball_miss, i_bricks_clear,
    output o_endgame, o_animate, o_paddle_lr, o_lives, o_state, o_demo
  );

  modport master (
    output i_ani_stb, i_btn_lr, i_ball_x, i_pad_x1, i_pad_x2, i_ball_miss, i_bricks_clear,
    input  o_endgame, o_animate, o_paddle_lr, o_lives, o_state, o_demo
  );
endinterface

// File: rtl/game_sequencer.sv
// Frame-level game phase controller with life counter and button/autopilot paddle arbitration.
// Define GAME_SEQ_DEMO_EN to include the idle timeout and the demo autopilot.
module game_sequencer #(
  parameter int LIVES        = 3,
  parameter int IDLE_FRAMES  = 600,
  parameter int SERVE_FRAMES = 60,
  parameter int MISS_FRAMES  = 90,
  parameter int HOLD_FRAMES  = 120,
  parameter int DEADBAND     = 8
) (
  input logic          i_clk,
  input logic          i_rst_n,
  game_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    MISS  = 3'd3,
    OVER  = 3'd4,
    WIN   = 3'd5
  } state_t;

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [1:0]       lives, lives_nxt;
  logic             demo, demo_nxt;
  logic             miss_lat, clear_lat;
  logic             miss_evt, clear_evt;
  logic             press;
  logic [1:0]       cmd;
  logic             endgame, animate;
  logic [1:0]       paddle_lr;

  assign press     = |bus.i_btn_lr;
  assign miss_evt  = miss_lat | bus.i_ball_miss;
  assign clear_evt = clear_lat | bus.i_bricks_clear;

`ifdef GAME_SEQ_DEMO_EN
  localparam logic DEMO_EN = 1'b1;
  logic [12:0] ball, left_lim, right_lim;

  assign ball      = {1'b0, bus.i_ball_x};
  assign left_lim  = {1'b0, bus.i_pad_x1} + 13'(DEADBAND);
  assign right_lim = ({1'b0, bus.i_pad_x2} >= 13'(DEADBAND)) ?
                     ({1'b0, bus.i_pad_x2} - 13'(DEADBAND)) : 13'd0;
  assign cmd = !demo            ? bus.i_btn_lr :
               (ball < left_lim)  ? 2'b10 :
               (ball > right_lim) ? 2'b01 : 2'b00;
`else
  localparam logic DEMO_EN = 1'b0;
  logic unused_pos;

  assign unused_pos = ^{bus.i_ball_x, bus.i_pad_x1, bus.i_pad_x2};
  assign cmd        = bus.i_btn_lr;
`endif

  // Phase decisions are made only on strobes; a demo abort overrides every other transition.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    lives_nxt = lives;
    demo_nxt  = demo;
    if (bus.i_ani_stb) begin
      cnt_nxt = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
      case (state)
        IDLE: begin
          if (press) begin
            state_nxt = SERVE;
            lives_nxt = 2'(LIVES);
            demo_nxt  = 1'b0;
          end else if (DEMO_EN && cnt == CNT_W'(IDLE_FRAMES - 1)) begin
            state_nxt = SERVE;
            lives_nxt = 2'(LIVES);
            demo_nxt  = 1'b1;
          end
        end
        SERVE: begin
          if (cnt == CNT_W'(SERVE_FRAMES - 1)) state_nxt = PLAY;
        end
        PLAY: begin
          if (miss_evt) begin
            state_nxt = MISS;
            lives_nxt = (lives != 2'd0) ? lives - 2'd1 : lives;
          end else if (clear_evt) begin
            state_nxt = WIN;
          end
        end
        MISS: begin
          if (cnt == CNT_W'(MISS_FRAMES - 1)) state_nxt = (lives == 2'd0) ? OVER : SERVE;
        end
        OVER, WIN: begin
          if (demo) begin
            if (cnt == CNT_W'(HOLD_FRAMES - 1)) begin
              state_nxt = IDLE;
              demo_nxt  = 1'b0;
            end
          end else if (cnt >= CNT_W'(HOLD_FRAMES) && press) begin
            state_nxt = SERVE;
            lives_nxt = 2'(LIVES);
            demo_nxt  = 1'b0;
          end
        end
        default: state_nxt = IDLE;
      endcase
      if (demo && press && (state == SERVE || state == PLAY || state == MISS)) begin
        state_nxt = IDLE;
        demo_nxt  = 1'b0;
        lives_nxt = 2'(LIVES);
      end
      if (state_nxt != state) cnt_nxt = '0;
    end
  end

  // Outputs are registered from the next state so they change on the same edge as o_state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      lives     <= 2'(LIVES);
      demo      <= 1'b0;
      miss_lat  <= 1'b0;
      clear_lat <= 1'b0;
      endgame   <= 1'b1;
      animate   <= 1'b0;
      paddle_lr <= 2'b00;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      lives     <= lives_nxt;
      demo      <= demo_nxt;
      miss_lat  <= bus.i_ani_stb ? 1'b0 : miss_evt;
      clear_lat <= bus.i_ani_stb ? 1'b0 : clear_evt;
      endgame   <= (state_nxt == IDLE) || (state_nxt == OVER) || (state_nxt == WIN);
      animate   <= (state_nxt == PLAY);
      paddle_lr <= (state_nxt == PLAY) ? cmd : 2'b00;
    end
  end

  assign bus.o_endgame   = endgame;
  assign bus.o_animate   = animate;
  assign bus.o_paddle_lr = paddle_lr;
  assign bus.o_lives     = lives;
  assign bus.o_state     = state;
  assign bus.o_demo      = demo;

endmodule
